// File: rtl/core_ctrl_pkg.sv
// Shared control encodings for the multi-cycle core: ALU operation codes,
// instruction opcode/funct values, datapath mux selects and the FSM state type.
package core_ctrl_pkg;

    // ALU operation codes driven on ALUctl
    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_SGE   = 4'd8;
    localparam logic [3:0] ALU_PASSA = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;
    localparam logic [3:0] ALU_NOR   = 4'd12;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_R_WB     = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_I_WB     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_MEM_WB   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_TRAP     = 4'd13
    } state_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// R-type funct decoder: maps funct to an ALU operation code and flags
// function codes the core does not implement.
module alu_ctl_decode
    import core_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctl,
    output logic       illegal
);

    // Pure lookup; unknown funct yields AND with the illegal flag raised
    always_comb begin
        alu_ctl = ALU_AND;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_NOR:  alu_ctl = ALU_NOR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the datapath mux selects, ALU control and memory handshake, counts
// retired instructions and traps on illegal encodings or memory timeout.
module multicycle_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic [3:0]       ALUctl,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             PCWrite,
    output logic [1:0]       PCSource,
    output logic             Trap,
    output logic [CNT_W-1:0] retired
);

    localparam logic [31:0] TO_LIMIT = 32'(MEM_TIMEOUT);

    state_t            state_reg, state_next;
    logic [31:0]       to_cnt_reg, to_cnt_next;
    logic [CNT_W-1:0]  retired_reg;
    logic              retire_inc;
    logic              timeout_hit;
    logic [3:0]        dec_alu;
    logic              dec_illegal;

    alu_ctl_decode u_alu_ctl_decode (
        .funct   (funct),
        .alu_ctl (dec_alu),
        .illegal (dec_illegal)
    );

    // The current stalled cycle is the last one allowed before trapping
    assign timeout_hit = (TO_LIMIT != 32'd0) && (to_cnt_reg == TO_LIMIT - 32'd1);
    assign retired     = retired_reg;

    // State, stall counter and retire counter; reset drops every strobe at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            to_cnt_reg  <= '0;
            retired_reg <= '0;
        end else begin
            state_reg  <= state_next;
            to_cnt_reg <= to_cnt_next;
            if (retire_inc)
                retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    // Next-state and output decode. Outputs follow the state register except
    // the BRANCH PC strobe (Zero) and the FETCH IR/PC strobes, which must
    // coincide with the memory handshake completing.
    always_comb begin
        state_next  = state_reg;
        to_cnt_next = '0;
        retire_inc  = 1'b0;
        ALUctl      = ALU_AND;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        PCWrite     = 1'b0;
        PCSource    = PCSRC_ALU;
        Trap        = 1'b0;

        case (state_reg)
            ST_IDLE: state_next = ST_FETCH;

            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ALUctl  = ALU_ADD;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = ST_DECODE;
                end else if (timeout_hit) begin
                    state_next = ST_TRAP;
                end else begin
                    to_cnt_next = to_cnt_reg + 32'd1;
                end
            end

            ST_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                ALUctl  = ALU_ADD;
                case (opcode)
                    OP_RTYPE:     state_next = ST_EXEC_R;
                    OP_LW, OP_SW: state_next = ST_MEM_ADDR;
                    OP_BEQ,
                    OP_BNE:       state_next = ST_BRANCH;
                    OP_ADDI:      state_next = ST_EXEC_I;
                    OP_J:         state_next = ST_JUMP;
                    default:      state_next = ST_TRAP;
                endcase
            end

            ST_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_RT;
                ALUctl     = dec_alu;
                state_next = dec_illegal ? ST_TRAP : ST_R_WB;
            end

            ST_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                retire_inc = 1'b1;
                state_next = ST_FETCH;
            end

            ST_EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUctl     = ALU_ADD;
                state_next = ST_I_WB;
            end

            ST_I_WB: begin
                RegWrite   = 1'b1;
                retire_inc = 1'b1;
                state_next = ST_FETCH;
            end

            ST_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUctl     = ALU_ADD;
                state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end

            ST_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)
                    state_next = ST_MEM_WB;
                else if (timeout_hit)
                    state_next = ST_TRAP;
                else
                    to_cnt_next = to_cnt_reg + 32'd1;
            end

            ST_MEM_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                retire_inc = 1'b1;
                state_next = ST_FETCH;
            end

            ST_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    retire_inc = 1'b1;
                    state_next = ST_FETCH;
                end else if (timeout_hit) begin
                    state_next = ST_TRAP;
                end else begin
                    to_cnt_next = to_cnt_reg + 32'd1;
                end
            end

            ST_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_RT;
                ALUctl     = ALU_SUB;
                PCSource   = PCSRC_ALUOUT;
                PCWrite    = (opcode == OP_BNE) ? !Zero : Zero;
                retire_inc = 1'b1;
                state_next = ST_FETCH;
            end

            ST_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                retire_inc = 1'b1;
                state_next = ST_FETCH;
            end

            ST_TRAP: Trap = 1'b1;

            default: state_next = ST_TRAP;
        endcase
    end

endmodule
